// File: rtl/pulse_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for pulse_arbiter.
package pulse_arb_pkg;

    localparam int unsigned MAX_REQ           = 8;
    localparam int unsigned IDX_W             = 3;
    localparam int unsigned GAP_DEFAULT       = 3;
    localparam int unsigned GAP_W_DEFAULT     = 8;
    localparam int unsigned REPEAT_DEFAULT    = 25000000;
    localparam int unsigned REPEAT_W_DEFAULT  = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request searching upward from ptr+1, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int unsigned        n);
        pick_t          p;
        logic [IDX_W:0] c;
        p = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            c = {1'b0, ptr} + (IDX_W+1)'(i);
            if (c >= (IDX_W+1)'(n)) c = c - (IDX_W+1)'(n);
            if (i <= n && !p.found && req[c[IDX_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = c[IDX_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/pulse_arbiter_trig_sync.sv
// Per-channel 3-flop synchroniser with rising-edge detect; optional auto-repeat
// under PULSE_ARB_AUTOREPEAT_EN.
module trig_sync
    import pulse_arb_pkg::*;
`ifdef PULSE_ARB_AUTOREPEAT_EN
#(
    parameter int unsigned REPEAT   = REPEAT_DEFAULT,
    parameter int unsigned REPEAT_W = REPEAT_W_DEFAULT
)
`endif
(
    input  logic iClk,
    input  logic iRst_n,
    input  logic iTrig,
    output logic oLevel,
    output logic oEdge
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;
    logic edge_c;

    always_comb begin
        s1_d = iTrig;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Reset high so a trigger held through reset release is not an edge.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign edge_c = s2_q & ~s3_q;
    assign oLevel = s2_q;

`ifdef PULSE_ARB_AUTOREPEAT_EN
    logic [REPEAT_W-1:0] cnt_q, cnt_d;
    logic                rep_c;

    always_comb begin
        cnt_d = cnt_q + REPEAT_W'(1);
        rep_c = 1'b0;
        if (!s2_q || edge_c) begin
            cnt_d = '0;
        end else if (cnt_q == REPEAT_W'(REPEAT - 1)) begin
            cnt_d = '0;
            rep_c = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign oEdge = edge_c | rep_c;
`else
    assign oEdge = edge_c;
`endif

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter turning async triggers into spaced one-hot pulses.
// Optional auto-repeat of held triggers: define PULSE_ARB_AUTOREPEAT_EN.
module pulse_arbiter
    import pulse_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned GAP      = GAP_DEFAULT,
    parameter int unsigned GAP_W    = GAP_W_DEFAULT,
    parameter int unsigned REPEAT   = REPEAT_DEFAULT,
    parameter int unsigned REPEAT_W = REPEAT_W_DEFAULT
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic [NUM_REQ-1:0] iTrig,
    input  logic               iEnable,
    output logic [NUM_REQ-1:0] oPulse,
    output logic [NUM_REQ-1:0] oPending,
    output logic               oBusy,
    output logic               oMerge
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_chk_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if ((64'(GAP) >> GAP_W) != 64'd0) begin : g_chk_gap
        $error("GAP does not fit in GAP_W");
    end
    if ((64'(REPEAT) >> REPEAT_W) != 64'd0) begin : g_chk_repeat
        $error("REPEAT does not fit in REPEAT_W");
    end

    logic [NUM_REQ-1:0] trig_edge;
    logic [NUM_REQ-1:0] unused_level;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
`ifdef PULSE_ARB_AUTOREPEAT_EN
        trig_sync #(.REPEAT(REPEAT), .REPEAT_W(REPEAT_W)) u_sync (
`else
        trig_sync u_sync (
`endif
            .iClk   (iClk),
            .iRst_n (iRst_n),
            .iTrig  (iTrig[i]),
            .oLevel (unused_level[i]),
            .oEdge  (trig_edge[i])
        );
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               merge_q, merge_d;
    logic [NUM_REQ-1:0] grant_c;
    pick_t              pick_c;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        pulse_d = '0;
        grant_c = '0;
        pick_c  = rr_pick(MAX_REQ'(pending_q), ptr_q, NUM_REQ);

        case (state_q)
            ST_IDLE: begin
                if (iEnable && pick_c.found) begin
                    state_d = ST_PULSE;
                    grant_c = NUM_REQ'(1) << pick_c.idx;
                    pulse_d = grant_c;
                    ptr_d   = pick_c.idx;
                end
            end
            ST_PULSE: begin
                gap_d   = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
                state_d = (GAP > 0) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge on the channel being granted re-arms it.
        pending_d = (pending_q & ~grant_c) | trig_edge;
        merge_d   = |(trig_edge & pending_q & ~grant_c);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            gap_q     <= '0;
            pending_q <= '0;
            pulse_q   <= '0;
            busy_q    <= 1'b0;
            merge_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            merge_q   <= merge_d;
        end
    end

    assign oPulse   = pulse_q;
    assign oPending = pending_q;
    assign oBusy    = busy_q;
    assign oMerge   = merge_q;

endmodule
